e203_dtcm_ram_ctrl: RTL and testbench
=====================================

Name: e203_dtcm_ram_ctrl

Overview:
- Front-end stage directly upstream of the DTCM SRAM wrapper.
- Converts one ICB command/response channel into the RAM's single-cycle cs/we/wem/addr/din port.
- Captures RAM read data, which is valid only in the cycle after access, and holds it until the response is accepted.
- Drives the RAM light-sleep pin from an idle-timeout state machine.

Parameters:
- ADDR_W, 32: ICB address width.
- RAM_AW, 14: RAM word-address width (64 KB).
- DW, 32: data width.
- MW, 4: byte-mask width (DW/8).
- BASE_ADDR, 32'h9000_0000: DTCM region base; the region size is 2^(RAM_AW+2) bytes.
- IDLE_CYC, 16: idle cycles before light sleep; 0 disables sleep.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command accepted
- icb_cmd_addr  in  ADDR_W  byte address
- icb_cmd_read  in  1  1=read, 0=write
- icb_cmd_wdata  in  DW  write data
- icb_cmd_wmask  in  MW  byte enables
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response accepted
- icb_rsp_rdata  out  DW  read data
- icb_rsp_err  out  1  address outside the DTCM region
- ram_cs  out  1  RAM chip select
- ram_we  out  1  RAM write enable
- ram_addr  out  RAM_AW  word address
- ram_wem  out  MW  write byte mask
- ram_din  out  DW  write data
- ram_dout  in  DW  RAM read data (valid the cycle after a read)
- ram_sd  out  1  shutdown; tied to 0
- ram_ds  out  1  deep sleep; tied to 0
- ram_ls  out  1  light sleep

Behaviour:
- Reset (asynchronous, active-low): state=ACTIVE, idle_cnt=0, rsp_valid=0, hold_vld=0, hold_data=0, err_q=0, ram_ls=0. All outputs are 0 during reset.
- Command ready: icb_cmd_ready = (state==ACTIVE) & (~icb_rsp_valid | icb_rsp_ready). At most one response is outstanding. Throughput is 1 transaction per cycle while rsp_ready stays high.
- Handshake: a transfer occurs when icb_cmd_valid & icb_cmd_ready.
- Region check: in_rgn = (icb_cmd_addr[ADDR_W-1:RAM_AW+2] == BASE_ADDR[ADDR_W-1:RAM_AW+2]).
- RAM drive (combinational, same cycle as the handshake):
  - ram_cs = hs & in_rgn; ram_we = ~icb_cmd_read.
  - ram_addr = icb_cmd_addr[RAM_AW+1:2]; ram_din = icb_cmd_wdata.
  - ram_wem = icb_cmd_read ? 0 : icb_cmd_wmask.
  - Address bits [1:0] are ignored.
- Response timing: on a handshake, at the next edge rsp_valid=1, rd_q=read & in_rgn, err_q=~in_rgn. Latency is exactly 1 cycle.
- Response data:
  - icb_rsp_rdata = hold_vld ? hold_data : (rd_q ? ram_dout : 0).
  - icb_rsp_err = err_q.
  - Write responses and error responses return rdata=0.
- Response stall: if rsp_valid & ~rsp_ready & ~hold_vld, capture ram_dout into hold_data and set hold_vld=1. The RAM output is not relied on after the first response cycle.
- Response completion: on rsp_valid & rsp_ready, clear hold_vld. Clear rsp_valid unless a new handshake occurs in the same cycle; a back-to-back handshake keeps rsp_valid=1.
- Idle counter: increments while state==ACTIVE & ~icb_cmd_valid & ~rsp_valid & IDLE_CYC!=0, saturating at IDLE_CYC. Any cmd_valid or rsp_valid clears it to 0.
- Sleep FSM:
  - ACTIVE -> SLEEP when idle_cnt==IDLE_CYC-1 and the idle condition still holds. ram_ls=1 is registered.
  - SLEEP: cmd_ready=0. On cmd_valid -> WAKE and ram_ls=0.
  - WAKE: cmd_ready=0, one cycle, then ACTIVE.
  - Wake penalty is 2 cycles from cmd_valid to the earliest handshake.
- Simultaneous events: cmd_valid in the same cycle the counter would expire cancels the sleep entry (stay ACTIVE).
- Reset mid-transaction: asynchronous clear drops any pending response. No response is ever issued for it.

Decomposition:
- Shared package e203_dtcm_pkg:
  - Constants: RAM_AW, DW, MW, BASE_ADDR.
  - Sleep state enum: ACTIVE=2'd0, SLEEP=2'd1, WAKE=2'd2.
- Sub-module e203_dtcm_lpm holds the idle counter and sleep FSM. Inputs: idle condition, cmd_valid. Outputs: ram_ls and active.

Test Plan:
- Write 0x9000_0010, wdata=0xDEADBEEF, wmask=4'hF -> same cycle ram_cs=1, we=1, addr=4, wem=F. Next cycle rsp_valid=1, rdata=0, err=0.
- Read 0x9000_0010 with rsp_ready=1 -> cs=1, we=0, wem=0. Next cycle rsp_rdata=0xDEADBEEF.
- Read, then hold rsp_ready=0 for 3 cycles while ram_dout changes to 0x0 -> rdata stays 0xDEADBEEF, cmd_ready=0. It completes on rsp_ready=1.
- Back-to-back: 4 reads with rsp_ready=1 -> 4 handshakes in 4 consecutive cycles, 4 responses in cycles 2-5 in order.
- Address 0x8000_0000 -> ram_cs stays 0. Next cycle rsp_err=1, rdata=0.
- IDLE_CYC=16, no traffic for 16 cycles -> ram_ls=1. Then cmd_valid -> ram_ls=0 next cycle, handshake 2 cycles after cmd_valid rises. Assert rst_n=0 while in SLEEP -> state ACTIVE, ram_ls=0 immediately.

Source files
------------

// File: rtl/e203_dtcm_ram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// e203_dtcm_pkg
// Shared constants and the light-sleep state encoding for the DTCM RAM
// front-end controller and its low-power sub-block.
// ---------------------------------------------------------------------------
package e203_dtcm_pkg;

    localparam int          RAM_AW    = 14;            // RAM word address (64 KB)
    localparam int          DW        = 32;            // data width
    localparam int          MW        = DW / 8;        // byte-mask width
    localparam logic [31:0] BASE_ADDR = 32'h9000_0000; // DTCM region base

    // Light-sleep controller states.
    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        SLEEP  = 2'd1,
        WAKE   = 2'd2
    } lpm_state_e;

endpackage

// File: rtl/e203_dtcm_ram_ctrl_if.sv
// ---------------------------------------------------------------------------
// e203_dtcm_ram_ctrl_if
// ICB command/response channel into the DTCM controller.
//   cmd: valid/ready, addr, read, wdata, wmask   (master -> slave)
//   rsp: valid/ready, rdata, err                 (slave -> master)
// Handshake: a beat transfers on a cycle where valid and ready are both high;
// valid is never withdrawn by the sender while waiting, and ready may depend
// combinationally on the receiver's state but never on the same-cycle valid.
// ---------------------------------------------------------------------------
interface e203_dtcm_ram_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DW     = 32,
    parameter int MW     = 4
);
    logic              icb_cmd_valid;
    logic              icb_cmd_ready;
    logic [ADDR_W-1:0] icb_cmd_addr;
    logic              icb_cmd_read;
    logic [DW-1:0]     icb_cmd_wdata;
    logic [MW-1:0]     icb_cmd_wmask;
    logic              icb_rsp_valid;
    logic              icb_rsp_ready;
    logic [DW-1:0]     icb_rsp_rdata;
    logic              icb_rsp_err;

    modport master (
        output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
               icb_cmd_wmask, icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );

    modport slave (
        input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
               icb_cmd_wmask, icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_valid, icb_rsp_rdata, icb_rsp_err
    );
endinterface

// File: rtl/e203_dtcm_ram_ctrl_lpm.sv
// ---------------------------------------------------------------------------
// e203_dtcm_lpm
// Idle counter plus ACTIVE/SLEEP/WAKE state machine driving RAM light sleep.
//   idle      in  : no command pending and no response outstanding
//   cmd_valid in  : command request (wakes the RAM)
//   ram_ls    out : registered light-sleep pin
//   active    out : controller may accept commands
//   dbg_state out : current state encoding
// IDLE_CYC = 0 disables sleep entirely.
// ---------------------------------------------------------------------------
module e203_dtcm_lpm
    import e203_dtcm_pkg::*;
#(
    parameter int unsigned IDLE_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       idle,
    input  logic       cmd_valid,
    output logic       ram_ls,
    output logic       active,
    output logic [1:0] dbg_state
);

    localparam int unsigned CW       = (IDLE_CYC < 2) ? 1 : $clog2(IDLE_CYC + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(IDLE_CYC);
    localparam logic [CW-1:0] CNT_LAST = CW'(IDLE_CYC - 1);
    localparam bit            SLEEP_EN = (IDLE_CYC != 0);

    lpm_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ls_q, ls_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ls_d    = ls_q;
        case (state_q)
            ACTIVE: begin
                if (idle && SLEEP_EN) begin
                    // A command arriving on the expiry cycle clears idle,
                    // so sleep entry is naturally cancelled.
                    if (cnt_q == CNT_LAST) begin
                        state_d = SLEEP;
                        ls_d    = 1'b1;
                    end
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                end
            end
            SLEEP: begin
                if (cmd_valid) begin
                    state_d = WAKE;
                    ls_d    = 1'b0;
                    cnt_d   = '0;
                end
            end
            WAKE: begin
                // One settling cycle after ls drops before the RAM is used.
                state_d = ACTIVE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ACTIVE;
                ls_d    = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACTIVE;
            cnt_q   <= '0;
            ls_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ls_q    <= ls_d;
        end
    end

    assign ram_ls    = ls_q;
    assign active    = (state_q == ACTIVE);
    assign dbg_state = state_q;

endmodule

// File: rtl/e203_dtcm_ram_ctrl.sv
// ---------------------------------------------------------------------------
// e203_dtcm_ram_ctrl
// Front end of the DTCM SRAM: turns one ICB command/response channel into a
// single-cycle RAM port and captures read data for a stalled response.
//   clk, rst_n     : clock, asynchronous active-low reset
//   icb            : ICB slave (cmd valid/ready/addr/read/wdata/wmask,
//                    rsp valid/ready/rdata/err)
//   ram_cs/we/addr/wem/din : RAM access, driven in the handshake cycle
//   ram_dout       : RAM read data, valid the cycle after a read
//   ram_sd/ds/ls   : RAM power pins (sd, ds tied low; ls from idle timeout)
//   dbg_lpm_state  : light-sleep state machine state
// ---------------------------------------------------------------------------
module e203_dtcm_ram_ctrl
    import e203_dtcm_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              RAM_AW    = e203_dtcm_pkg::RAM_AW,
    parameter int              DW        = e203_dtcm_pkg::DW,
    parameter int              MW        = e203_dtcm_pkg::MW,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(e203_dtcm_pkg::BASE_ADDR),
    parameter int unsigned     IDLE_CYC  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    e203_dtcm_ram_ctrl_if.slave icb,
    output logic              ram_cs,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [MW-1:0]     ram_wem,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_dout,
    output logic              ram_sd,
    output logic              ram_ds,
    output logic              ram_ls,
    output logic [1:0]        dbg_lpm_state
);

    logic          active, hs, in_rgn, idle;
    logic [DW-1:0] rd_data;

    logic          rsp_valid_q, rsp_valid_d;
    logic          rd_q, rd_d;
    logic          err_q, err_d;
    logic          hold_vld_q, hold_vld_d;
    logic [DW-1:0] hold_data_q, hold_data_d;

    // Byte-offset bits are ignored by a word-wide RAM.
    logic unused_addr_lsb;
    assign unused_addr_lsb = &{1'b0, icb.icb_cmd_addr[1:0]};

    assign in_rgn = (icb.icb_cmd_addr[ADDR_W-1:RAM_AW+2] == BASE_ADDR[ADDR_W-1:RAM_AW+2]);

    // Ready is masked by rst_n so every output reads 0 while reset is held.
    assign icb.icb_cmd_ready = rst_n & active & (~rsp_valid_q | icb.icb_rsp_ready);
    assign hs                = icb.icb_cmd_valid & icb.icb_cmd_ready;

    assign ram_cs   = hs & in_rgn;
    assign ram_we   = rst_n & ~icb.icb_cmd_read;
    assign ram_addr = rst_n ? icb.icb_cmd_addr[RAM_AW+1:2] : '0;
    assign ram_wem  = (rst_n & ~icb.icb_cmd_read) ? icb.icb_cmd_wmask : '0;
    assign ram_din  = rst_n ? icb.icb_cmd_wdata : '0;
    assign ram_sd   = 1'b0;
    assign ram_ds   = 1'b0;

    // Write and error responses carry zero data; only a real read shows dout.
    assign rd_data           = rd_q ? ram_dout : '0;
    assign icb.icb_rsp_valid = rsp_valid_q;
    assign icb.icb_rsp_rdata = hold_vld_q ? hold_data_q : rd_data;
    assign icb.icb_rsp_err   = err_q;

    assign idle = ~icb.icb_cmd_valid & ~rsp_valid_q;

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rd_d        = rd_q;
        err_d       = err_q;
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;
        if (rsp_valid_q && icb.icb_rsp_ready) begin
            rsp_valid_d = 1'b0;
            hold_vld_d  = 1'b0;
        end else if (rsp_valid_q && !hold_vld_q) begin
            // RAM output is only guaranteed in the first response cycle.
            hold_vld_d  = 1'b1;
            hold_data_d = rd_data;
        end
        // A new accept overrides completion so back-to-back keeps valid high.
        if (hs) begin
            rsp_valid_d = 1'b1;
            rd_d        = icb.icb_cmd_read & in_rgn;
            err_d       = ~in_rgn;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rd_q        <= 1'b0;
            err_q       <= 1'b0;
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
        end
    end

    e203_dtcm_lpm #(
        .IDLE_CYC (IDLE_CYC)
    ) u_lpm (
        .clk       (clk),
        .rst_n     (rst_n),
        .idle      (idle),
        .cmd_valid (icb.icb_cmd_valid),
        .ram_ls    (ram_ls),
        .active    (active),
        .dbg_state (dbg_lpm_state)
    );

endmodule

// File: tb/tb_e203_dtcm_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_e203_dtcm_ram_ctrl
// Directed and randomized traffic against a word-addressed memory model.
// Expected responses are queued at command accept and checked by a separate
// monitor when the response is accepted.
// ---------------------------------------------------------------------------
module tb_e203_dtcm_ram_ctrl;

    localparam int          IDLE      = 16;
    localparam logic [1:0]  ST_ACTIVE = 2'd0;
    localparam logic [1:0]  ST_SLEEP  = 2'd1;
    localparam logic [1:0]  ST_WAKE   = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    e203_dtcm_ram_ctrl_if icb ();

    logic        ram_cs, ram_we, ram_sd, ram_ds, ram_ls;
    logic [13:0] ram_addr;
    logic [3:0]  ram_wem;
    logic [31:0] ram_din, ram_dout;
    logic [1:0]  dbg_state;

    e203_dtcm_ram_ctrl #(.IDLE_CYC(IDLE)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb           (icb),
        .ram_cs        (ram_cs),
        .ram_we        (ram_we),
        .ram_addr      (ram_addr),
        .ram_wem       (ram_wem),
        .ram_din       (ram_din),
        .ram_dout      (ram_dout),
        .ram_sd        (ram_sd),
        .ram_ds        (ram_ds),
        .ram_ls        (ram_ls),
        .dbg_lpm_state (dbg_state)
    );

    // ---------------- SRAM model: dout valid only the cycle after a read ----
    logic [31:0] ram_arr [0:16383];
    always @(posedge clk) begin
        if (ram_cs && ram_we)
            for (int b = 0; b < 4; b++)
                if (ram_wem[b]) ram_arr[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
        ram_dout <= (ram_cs && !ram_we) ? ram_arr[ram_addr] : $urandom;
    end

    // ---------------- scoreboard state ----------------
    logic [32:0] exp_q[$];           // {err, rdata}
    logic [31:0] ref_mem [int];      // reference memory by word index
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          hs_now   = 0;
    bit          chk_ready = 0;
    int          rdy_mode = 0;
    int          cyc = 0;
    int          last_hs_cyc = 0;
    logic [32:0] mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    task automatic issue(input logic [31:0] addr, input bit rd, input logic [31:0] wd,
                         input logic [3:0] wm, output int w);
        bit          in_r;
        int          idx;
        logic [31:0] word;
        icb.icb_cmd_valid = 1'b1;
        icb.icb_cmd_addr  = addr;
        icb.icb_cmd_read  = rd;
        icb.icb_cmd_wdata = wd;
        icb.icb_cmd_wmask = wm;
        w = 0;
        forever begin
            @(negedge clk);
            if (icb.icb_cmd_ready) break;
            w++;
            if (w > 50) begin
                n_checks++;
                n_fail++;
                $display("FAIL cmd_timeout: no cmd_ready within 50 cycles, addr 0x%0h", addr);
                icb.icb_cmd_valid = 1'b0;
                return;
            end
        end
        in_r        = (addr[31:16] == 16'h9000);
        idx         = int'(addr[15:2]);
        hs_now      = 1'b1;
        last_hs_cyc = cyc;
        check("ram_cs", ram_cs, in_r);
        if (in_r) begin
            check("ram_we", ram_we, !rd);
            check("ram_addr", ram_addr, addr[15:2]);
            check("ram_wem", ram_wem, rd ? 4'h0 : wm);
            check("ram_din", ram_din, wd);
        end
        if (!in_r) begin
            exp_q.push_back({1'b1, 32'h0});
        end else if (rd) begin
            exp_q.push_back({1'b0, ref_mem.exists(idx) ? ref_mem[idx] : 32'h0});
        end else begin
            word = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (wm[b]) word[8*b +: 8] = wd[8*b +: 8];
            ref_mem[idx] = word;
            exp_q.push_back({1'b0, 32'h0});
        end
        @(posedge clk);
        #1;
        hs_now            = 1'b0;
        icb.icb_cmd_valid = 1'b0;
    endtask

    // Random response back-pressure.
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) icb.icb_rsp_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        #1;
        if (rst_n) begin
            check("rsp_valid", icb.icb_rsp_valid, (exp_q.size() - int'(hs_now)) > 0);
            if (chk_ready) begin
                check("cmd_ready", icb.icb_cmd_ready, !icb.icb_rsp_valid || icb.icb_rsp_ready);
                check("ram_ls_awake", ram_ls, 1'b0);
            end
            if (icb.icb_rsp_valid && icb.icb_rsp_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rsp_unexpected: rdata 0x%0h err %0b with nothing outstanding",
                             icb.icb_rsp_rdata, icb.icb_rsp_err);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("rsp_err", icb.icb_rsp_err, mon_e[32]);
                    check("rsp_rdata", icb.icb_rsp_rdata, mon_e[31:0]);
                end
            end
        end
    end

    // Hard stop so a hung DUT can never stall the run.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int          w;
        int          hc [4];
        int          t;
        bit          rd;
        logic [31:0] a;

        rst_n             = 1'b0;
        icb.icb_cmd_valid = 1'b0;
        icb.icb_cmd_addr  = '0;
        icb.icb_cmd_read  = 1'b0;
        icb.icb_cmd_wdata = '0;
        icb.icb_cmd_wmask = '0;
        icb.icb_rsp_ready = 1'b1;

        // Reset state: a pending write request must not leak through.
        repeat (3) @(posedge clk);
        #1;
        icb.icb_cmd_valid = 1'b1;
        icb.icb_cmd_addr  = 32'h9000_0010;
        @(negedge clk);
        check("rst_cmd_ready", icb.icb_cmd_ready, 1'b0);
        check("rst_ram_cs", ram_cs, 1'b0);
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_rsp_valid", icb.icb_rsp_valid, 1'b0);
        check("rst_rsp_rdata", icb.icb_rsp_rdata, 32'h0);
        check("rst_rsp_err", icb.icb_rsp_err, 1'b0);
        check("rst_ram_ls", ram_ls, 1'b0);
        check("rst_sd_ds", {ram_sd, ram_ds}, 2'b00);
        check("rst_state", dbg_state, ST_ACTIVE);
        icb.icb_cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        chk_ready = 1'b1;

        // Write then read back the same word.
        issue(32'h9000_0010, 1'b0, 32'hDEAD_BEEF, 4'hF, w);
        issue(32'h9000_0010, 1'b1, 32'h0, 4'h0, w);
        @(posedge clk);
        #1;

        // Stalled read response must hold its data while dout churns.
        icb.icb_rsp_ready = 1'b0;
        issue(32'h9000_0010, 1'b1, 32'h0, 4'h0, w);
        repeat (3) begin
            @(negedge clk);
            check("hold_rdata", icb.icb_rsp_rdata, 32'hDEAD_BEEF);
            check("hold_cmd_ready", icb.icb_cmd_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        icb.icb_rsp_ready = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back reads: one accept per cycle.
        for (int i = 0; i < 4; i++)
            issue(32'h9000_0100 + 32'(4*i), 1'b0, 32'h1111_0000 + 32'(i), 4'hF, w);
        for (int i = 0; i < 4; i++) begin
            issue(32'h9000_0100 + 32'(4*i), 1'b1, 32'h0, 4'h0, w);
            hc[i] = last_hs_cyc;
        end
        for (int i = 1; i < 4; i++) check("b2b_gap", hc[i] - hc[i-1], 1);

        // Region boundaries and ignored byte offset.
        issue(32'h8000_0000, 1'b1, 32'h0, 4'h0, w);
        issue(32'h9001_0000, 1'b0, 32'h1234_5678, 4'hF, w);
        issue(32'h8FFF_FFFC, 1'b1, 32'h0, 4'h0, w);
        issue(32'h9000_FFFF, 1'b0, 32'hCAFE_F00D, 4'h5, w);
        issue(32'h9000_FFFC, 1'b1, 32'h0, 4'h0, w);

        // Randomized traffic with random back-pressure.
        rdy_mode = 1;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            a = {16'h9000, 8'h00, 6'($urandom), 2'($urandom)};
            if ($urandom_range(0, 9) == 0)
                a[31:16] = ($urandom_range(0, 1) != 0) ? 16'h9001 : 16'h8FFF;
            rd = ($urandom_range(0, 1) != 0);
            if (rd && a[31:16] == 16'h9000 && !ref_mem.exists(int'(a[15:2]))) rd = 1'b0;
            issue(a, rd, $urandom, 4'($urandom), w);
        end
        rdy_mode = 0;
        @(posedge clk);
        #2;
        icb.icb_rsp_ready = 1'b1;
        t = 0;
        while ((exp_q.size() != 0) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses still outstanding", exp_q.size());
        end

        // Idle timeout: sleep exactly after IDLE idle cycles.
        chk_ready = 1'b0;
        issue(32'h9000_0020, 1'b0, 32'h0BAD_CAFE, 4'hF, w);
        @(posedge clk);
        #1;                                  // first fully idle cycle
        repeat (IDLE - 1) @(posedge clk);
        @(negedge clk);
        check("ls_before_timeout", ram_ls, 1'b0);
        check("state_before_timeout", dbg_state, ST_ACTIVE);
        @(negedge clk);
        check("ls_asleep", ram_ls, 1'b1);
        check("state_asleep", dbg_state, ST_SLEEP);
        check("sleep_cmd_ready", icb.icb_cmd_ready, 1'b0);

        // Wake: ls drops next cycle, accept two cycles after valid rises.
        @(posedge clk);
        #1;
        icb.icb_cmd_valid = 1'b1;
        icb.icb_cmd_addr  = 32'h9000_0020;
        icb.icb_cmd_read  = 1'b1;
        @(negedge clk);
        check("wake_t0_ready", icb.icb_cmd_ready, 1'b0);
        check("wake_t0_ls", ram_ls, 1'b1);
        @(negedge clk);
        check("wake_t1_ready", icb.icb_cmd_ready, 1'b0);
        check("wake_t1_ls", ram_ls, 1'b0);
        check("wake_t1_state", dbg_state, ST_WAKE);
        issue(32'h9000_0020, 1'b1, 32'h0, 4'h0, w);
        check("wake_t2_accept", w, 0);

        // Command on the expiry cycle cancels sleep entry.
        @(posedge clk);
        #1;
        repeat (IDLE - 1) begin
            @(posedge clk);
            #1;
        end
        issue(32'h9000_0024, 1'b0, 32'h5555_AAAA, 4'h3, w);
        check("cancel_accept", w, 0);
        @(negedge clk);
        check("cancel_ls", ram_ls, 1'b0);
        check("cancel_state", dbg_state, ST_ACTIVE);

        // Asynchronous reset while asleep.
        repeat (IDLE + 2) @(posedge clk);
        @(negedge clk);
        check("ls_before_reset", ram_ls, 1'b1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("reset_ls", ram_ls, 1'b0);
        check("reset_state", dbg_state, ST_ACTIVE);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Asynchronous reset drops a pending response.
        icb.icb_rsp_ready = 1'b0;
        issue(32'h9000_0020, 1'b1, 32'h0, 4'h0, w);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        check("reset_drop_rsp", icb.icb_rsp_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n             = 1'b1;
        icb.icb_rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        issue(32'h9000_0024, 1'b1, 32'h0, 4'h0, w);
        repeat (3) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
